// File: rtl/dafx_axi_reg_bank.sv
// AXI4-Lite register bank for the DAFX audio datapath: read/write control
// registers, read-only status registers and a self-clearing command word.
// AW and W are captured in independent holding registers and committed
// together. Each commit raises a per-register write strobe for one cycle.
module dafx_axi_reg_bank #(
  parameter int AXI_ADDR_WIDTH_P = 16,
  parameter int AXI_DATA_WIDTH_P = 32,
  parameter int NR_CR_P          = 8,
  parameter int NR_SR_P          = 8,
  parameter int NR_CMD_P         = 4,
  parameter int SR_BASE_P        = 64,
  parameter int CMD_BASE_P       = 128,
  parameter logic [NR_CR_P*AXI_DATA_WIDTH_P-1:0] CR_RESET_P = '0
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [AXI_ADDR_WIDTH_P-1:0]           awaddr,
  input  logic                                  awvalid,
  output logic                                  awready,
  input  logic [AXI_DATA_WIDTH_P-1:0]           wdata,
  input  logic [AXI_DATA_WIDTH_P/8-1:0]         wstrb,
  input  logic                                  wvalid,
  output logic                                  wready,
  output logic [1:0]                            bresp,
  output logic                                  bvalid,
  input  logic                                  bready,
  input  logic [AXI_ADDR_WIDTH_P-1:0]           araddr,
  input  logic                                  arvalid,
  output logic                                  arready,
  output logic [AXI_DATA_WIDTH_P-1:0]           rdata,
  output logic [1:0]                            rresp,
  output logic                                  rvalid,
  input  logic                                  rready,
  output logic [NR_CR_P*AXI_DATA_WIDTH_P-1:0]   cr_o,
  output logic [NR_CR_P-1:0]                    cr_wr_o,
  input  logic [NR_SR_P*AXI_DATA_WIDTH_P-1:0]   sr_i,
  output logic [NR_CMD_P-1:0]                   cmd_o
);

  localparam int DW     = AXI_DATA_WIDTH_P;
  localparam int STRB_W = DW / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = AXI_ADDR_WIDTH_P - OFF_W;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [DW-1:0] UNMAPPED_DATA = DW'(32'hBAAD_FACE);

  localparam logic [IDX_W-1:0] CR_END_IDX   = IDX_W'(NR_CR_P);
  localparam logic [IDX_W-1:0] CMD_IDX      = IDX_W'(CMD_BASE_P);

  logic                 aw_full, w_full;
  logic [IDX_W-1:0]     aw_idx_q;
  logic [DW-1:0]        w_data_q;
  logic [STRB_W-1:0]    w_strb_q;
  logic                 commit;

  logic [NR_CR_P*DW-1:0] cr_q, cr_d;
  logic [NR_CR_P-1:0]    cr_wr_q, cr_wr_d;
  logic [NR_CMD_P-1:0]   cmd_q, cmd_d;
  logic [1:0]            wr_resp_d;

  logic [IDX_W-1:0]      ar_idx;
  logic [DW-1:0]         rd_data_d;
  logic [1:0]            rd_resp_d;

  assign awready = !aw_full;
  assign wready  = !w_full;
  assign arready = !rvalid;
  // A commit may overwrite a response in the same edge that retires it.
  assign commit  = aw_full && w_full && (!bvalid || bready);
  assign ar_idx  = araddr[AXI_ADDR_WIDTH_P-1:OFF_W];

  assign cr_o    = cr_q;
  assign cr_wr_o = cr_wr_q;
  assign cmd_o   = cmd_q;

  // Address holding register: one write address waiting for its data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_full  <= 1'b0;
      aw_idx_q <= '0;
    end else if (commit) begin
      aw_full <= 1'b0;
    end else if (awvalid && awready) begin
      aw_full  <= 1'b1;
      aw_idx_q <= awaddr[AXI_ADDR_WIDTH_P-1:OFF_W];
    end
  end

  // Data holding register: one write beat waiting for its address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_full   <= 1'b0;
      w_data_q <= '0;
      w_strb_q <= '0;
    end else if (commit) begin
      w_full <= 1'b0;
    end else if (wvalid && wready) begin
      w_full   <= 1'b1;
      w_data_q <= wdata;
      w_strb_q <= wstrb;
    end
  end

  // Write decode: byte-lane merge into CRs, command bits, and response code.
  always_comb begin
    cr_d      = cr_q;
    cr_wr_d   = '0;
    cmd_d     = '0;
    wr_resp_d = RESP_SLVERR;
    if (aw_idx_q < CR_END_IDX || aw_idx_q == CMD_IDX) wr_resp_d = RESP_OKAY;
    if (commit) begin
      for (int i = 0; i < NR_CR_P; i++) begin
        if (aw_idx_q == IDX_W'(i)) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (w_strb_q[b]) cr_d[i*DW + b*8 +: 8] = w_data_q[b*8 +: 8];
          end
          cr_wr_d[i] = |w_strb_q;
        end
      end
      if (aw_idx_q == CMD_IDX) begin
        for (int i = 0; i < NR_CMD_P; i++) cmd_d[i] = w_data_q[i] & w_strb_q[i/8];
      end
    end
  end

  // Register state plus the one-cycle write and command pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cr_q    <= CR_RESET_P;
      cr_wr_q <= '0;
      cmd_q   <= '0;
    end else begin
      cr_q    <= cr_d;
      cr_wr_q <= cr_wr_d;
      cmd_q   <= cmd_d;
    end
  end

  // Write response channel: set on commit, held until the master takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bvalid <= 1'b0;
      bresp  <= RESP_OKAY;
    end else if (commit) begin
      bvalid <= 1'b1;
      bresp  <= wr_resp_d;
    end else if (bready) begin
      bvalid <= 1'b0;
    end
  end

  // Read decode from pre-edge register contents and live status inputs.
  always_comb begin
    rd_data_d = UNMAPPED_DATA;
    rd_resp_d = RESP_SLVERR;
    for (int i = 0; i < NR_CR_P; i++) begin
      if (ar_idx == IDX_W'(i)) begin
        rd_data_d = cr_q[i*DW +: DW];
        rd_resp_d = RESP_OKAY;
      end
    end
    for (int i = 0; i < NR_SR_P; i++) begin
      if (ar_idx == IDX_W'(SR_BASE_P + i)) begin
        rd_data_d = sr_i[i*DW +: DW];
        rd_resp_d = RESP_OKAY;
      end
    end
    if (ar_idx == CMD_IDX) begin
      rd_data_d = '0;
      rd_resp_d = RESP_OKAY;
    end
  end

  // Read data channel: single-entry, latency one, held until rready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= RESP_OKAY;
    end else if (arvalid && arready) begin
      rvalid <= 1'b1;
      rdata  <= rd_data_d;
      rresp  <= rd_resp_d;
    end else if (rready) begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dafx_axi_reg_bank.sv
// Directed bench for dafx_axi_reg_bank: a vector table of single reads and
// writes, followed by hand-written backpressure, collision and reset sequences.
module tb_dafx_axi_reg_bank;

  localparam logic [255:0] CR_RST = (256'h7000_0007 << 224) | (256'hC0DE_0002 << 64);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [15:0]  awaddr;
  logic         awvalid, awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wvalid, wready;
  logic [1:0]   bresp;
  logic         bvalid, bready;
  logic [15:0]  araddr;
  logic         arvalid, arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid, rready;
  logic [255:0] cr_o;
  logic [7:0]   cr_wr_o;
  logic [255:0] sr_i;
  logic [3:0]   cmd_o;

  int n_chk = 0;
  int n_pass = 0;

  dafx_axi_reg_bank #(.CR_RESET_P(CR_RST)) dut (
    .clk(clk), .rst_n(rst_n),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .cr_o(cr_o), .cr_wr_o(cr_wr_o), .sr_i(sr_i), .cmd_o(cmd_o)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    bit          is_wr;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          lead;
    logic [1:0]  exp_resp;
    logic [31:0] exp_data;
    logic [7:0]  exp_wr;
    logic [3:0]  exp_cmd;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic void add_wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                                 input int lead, input logic [1:0] resp, input logic [7:0] wr,
                                 input logic [3:0] cmd);
    vec_t v;
    v.is_wr = 1'b1; v.addr = a; v.data = d; v.strb = s; v.lead = lead;
    v.exp_resp = resp; v.exp_data = '0; v.exp_wr = wr; v.exp_cmd = cmd;
    vq.push_back(v);
  endfunction

  function automatic void add_rd(input logic [15:0] a, input logic [31:0] d, input logic [1:0] resp);
    vec_t v;
    v.is_wr = 1'b0; v.addr = a; v.data = '0; v.strb = '0; v.lead = 0;
    v.exp_resp = resp; v.exp_data = d; v.exp_wr = '0; v.exp_cmd = '0;
    vq.push_back(v);
  endfunction

  // Advance one clock, dropping any valid whose handshake completed at that edge.
  task automatic step();
    logic hs_aw, hs_w, hs_ar;
    hs_aw = awvalid && awready;
    hs_w  = wvalid && wready;
    hs_ar = arvalid && arready;
    @(posedge clk); #1;
    if (hs_aw) awvalid = 1'b0;
    if (hs_w)  wvalid  = 1'b0;
    if (hs_ar) arvalid = 1'b0;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int lead, output logic [1:0] resp, output logic [7:0] wr,
                          output logic [3:0] cmd, output logic [11:0] after, output logic ok);
    bit aw_sent = 0;
    ok = 1'b0; resp = '0; wr = '0; cmd = '0; after = '0;
    wdata = d; wstrb = s; wvalid = 1'b1; awaddr = a;
    for (int c = 0; c < 50; c++) begin
      if (!aw_sent && c >= lead) begin awvalid = 1'b1; aw_sent = 1; end
      if (bvalid) begin ok = 1'b1; break; end
      step();
    end
    resp = bresp; wr = cr_wr_o; cmd = cmd_o;
    step();
    after = {cr_wr_o, cmd_o};
  endtask

  task automatic do_read(input logic [15:0] a, output logic [31:0] d, output logic [1:0] resp,
                         output logic ok);
    ok = 1'b0; d = '0; resp = '0;
    araddr = a; arvalid = 1'b1;
    for (int c = 0; c < 50; c++) begin
      step();
      if (rvalid) begin ok = 1'b1; break; end
    end
    d = rdata; resp = rresp;
    step();
  endtask

  logic [1:0]  t_resp;
  logic [7:0]  t_wr;
  logic [3:0]  t_cmd;
  logic [11:0] t_after;
  logic [31:0] t_data;
  logic        t_ok;
  int          waited;

  initial begin
    rst_n = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b1; araddr = '0; arvalid = 1'b0; rready = 1'b1;
    for (int i = 0; i < 8; i++) sr_i[i*32 +: 32] = 32'h5A00_0000 | 32'(i);

    add_rd(16'h0008, 32'hC0DE_0002, OKAY);
    add_rd(16'h001C, 32'h7000_0007, OKAY);
    add_wr(16'h0004, 32'h1234_5678, 4'hF, 3, OKAY, 8'h02, 4'h0);
    add_rd(16'h0004, 32'h1234_5678, OKAY);
    add_wr(16'h0000, 32'hAABB_CCDD, 4'hF, 0, OKAY, 8'h01, 4'h0);
    add_wr(16'h0000, 32'h1122_3344, 4'b0101, 1, OKAY, 8'h01, 4'h0);
    add_rd(16'h0000, 32'hAA22_CC44, OKAY);
    add_wr(16'h0200, 32'h0000_0005, 4'hF, 0, OKAY, 8'h00, 4'b0101);
    add_rd(16'h0200, 32'h0000_0000, OKAY);
    add_wr(16'h0100, 32'hFFFF_FFFF, 4'hF, 0, SLVERR, 8'h00, 4'h0);
    add_rd(16'h07FC, 32'hBAAD_FACE, SLVERR);
    add_rd(16'h0104, 32'h5A00_0001, OKAY);
    add_wr(16'h000C, 32'h0000_FFFF, 4'h0, 0, OKAY, 8'h00, 4'h0);
    add_rd(16'h000C, 32'h0000_0000, OKAY);
    add_wr(16'h001F, 32'h0F0F_0F0F, 4'hF, 2, OKAY, 8'h80, 4'h0);
    add_rd(16'h001E, 32'h0F0F_0F0F, OKAY);
    add_wr(16'h0200, 32'h0000_00FA, 4'b0001, 0, OKAY, 8'h00, 4'hA);
    add_wr(16'h0200, 32'h0000_000F, 4'b1110, 0, OKAY, 8'h00, 4'h0);
    add_wr(16'h07FC, 32'hFFFF_FFFF, 4'hF, 0, SLVERR, 8'h00, 4'h0);
    add_rd(16'h0000, 32'hAA22_CC44, OKAY);
    add_rd(16'h0004, 32'h1234_5678, OKAY);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_cr", cr_o, CR_RST);
    chk("reset_outs", 256'({bvalid, bresp, rvalid, rresp, rdata, cr_wr_o, cmd_o}), 256'(0));
    chk("reset_readies", 256'({awready, wready, arready}), 256'(3'b111));
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();

    foreach (vq[k]) begin
      if (vq[k].is_wr) begin
        do_write(vq[k].addr, vq[k].data, vq[k].strb, vq[k].lead, t_resp, t_wr, t_cmd, t_after, t_ok);
        chk($sformatf("v%0d_bvalid", k), 256'(t_ok), 256'(1));
        chk($sformatf("v%0d_bresp", k), 256'(t_resp), 256'(vq[k].exp_resp));
        chk($sformatf("v%0d_cr_wr", k), 256'(t_wr), 256'(vq[k].exp_wr));
        chk($sformatf("v%0d_cmd", k), 256'(t_cmd), 256'(vq[k].exp_cmd));
        chk($sformatf("v%0d_pulse_end", k), 256'(t_after), 256'(0));
      end else begin
        do_read(vq[k].addr, t_data, t_resp, t_ok);
        chk($sformatf("v%0d_rvalid", k), 256'(t_ok), 256'(1));
        chk($sformatf("v%0d_rdata", k), 256'(t_data), 256'(vq[k].exp_data));
        chk($sformatf("v%0d_rresp", k), 256'(t_resp), 256'(vq[k].exp_resp));
      end
    end
    chk("cr_after_table", 256'({cr_o[0 +: 32], cr_o[32 +: 32], cr_o[64 +: 32], cr_o[224 +: 32]}),
        256'({32'hAA22_CC44, 32'h1234_5678, 32'hC0DE_0002, 32'h0F0F_0F0F}));

    // Write backpressure: second write waits in holding regs, no commit.
    bready = 1'b0;
    awaddr = 16'h0010; awvalid = 1'b1; wdata = 32'h4444_4444; wstrb = 4'hF; wvalid = 1'b1;
    waited = 0;
    while (!bvalid && waited < 20) begin step(); waited++; end
    chk("bp_w_first_bvalid", 256'(bvalid), 256'(1));
    awaddr = 16'h0010; awvalid = 1'b1; wdata = 32'h5555_5555; wvalid = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp_w_hold%0d", i),
          256'({bvalid, bresp, awready, wready, cr_o[128 +: 32], cr_wr_o}),
          256'({1'b1, OKAY, 1'b0, 1'b0, 32'h4444_4444, 8'h00}));
      step();
    end
    bready = 1'b1;
    step();
    chk("bp_w_second_commit", 256'({bvalid, cr_o[128 +: 32], cr_wr_o}),
        256'({1'b1, 32'h5555_5555, 8'h10}));
    step();
    chk("bp_w_drain", 256'(bvalid), 256'(0));

    // Read backpressure: data must not follow a changing status input.
    rready = 1'b0;
    araddr = 16'h0100; arvalid = 1'b1;
    step();
    chk("bp_r_rvalid", 256'(rvalid), 256'(1));
    sr_i[31:0] = 32'hFFFF_0000;
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp_r_hold%0d", i), 256'({rvalid, arready, rresp, rdata}),
          256'({1'b1, 1'b0, OKAY, 32'h5A00_0000}));
      step();
    end
    rready = 1'b1;
    step();
    chk("bp_r_drain", 256'(rvalid), 256'(0));
    sr_i[31:0] = 32'h5A00_0000;

    // Read accepted on the same edge as a write commit to that CR sees the old value.
    do_write(16'h0014, 32'h1111_1111, 4'hF, 0, t_resp, t_wr, t_cmd, t_after, t_ok);
    chk("coll_setup", 256'({t_ok, cr_o[160 +: 32]}), 256'({1'b1, 32'h1111_1111}));
    awaddr = 16'h0014; awvalid = 1'b1; wdata = 32'h2222_2222; wstrb = 4'hF; wvalid = 1'b1;
    step();
    araddr = 16'h0014; arvalid = 1'b1;
    step();
    chk("coll_read_old", 256'({rvalid, rdata}), 256'({1'b1, 32'h1111_1111}));
    chk("coll_write_new", 256'({bvalid, cr_o[160 +: 32], cr_wr_o}),
        256'({1'b1, 32'h2222_2222, 8'h20}));
    step();
    chk("coll_drain", 256'({rvalid, bvalid}), 256'(0));

    // Reset mid-transaction: accepted W beat is discarded.
    do_read(16'h07FC, t_data, t_resp, t_ok);
    chk("pre_rst_read", 256'({t_ok, t_resp, t_data}), 256'({1'b1, SLVERR, 32'hBAAD_FACE}));
    wdata = 32'h6666_6666; wstrb = 4'hF; wvalid = 1'b1;
    step();
    #2;
    rst_n = 1'b0;
    awvalid = 1'b0; wvalid = 1'b0;
    #1;
    chk("mid_rst_cr", cr_o, CR_RST);
    chk("mid_rst_outs", 256'({bvalid, bresp, rvalid, rresp, rdata, cr_wr_o, cmd_o}), 256'(0));
    chk("mid_rst_readies", 256'({awready, wready, arready}), 256'(3'b111));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    awaddr = 16'h0018; awvalid = 1'b1;
    step();
    repeat (4) step();
    chk("post_rst_no_commit", 256'({bvalid, cr_o[192 +: 32], cr_wr_o, awready, wready}),
        256'({1'b0, 32'h0, 8'h00, 1'b0, 1'b1}));
    wdata = 32'h0000_6600; wstrb = 4'hF; wvalid = 1'b1;
    waited = 0;
    while (!bvalid && waited < 20) begin step(); waited++; end
    chk("post_rst_commit", 256'({bvalid, bresp, cr_o[192 +: 32], cr_wr_o}),
        256'({1'b1, OKAY, 32'h0000_6600, 8'h40}));
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
